riscv_irq_event_unit: RTL and testbench
=======================================

RISCV_IRQ_EVENT_UNIT -- requirements
Module: riscv_irq_event_unit

Interface
REQ-001 The block SHALL have parameter NUM_LINES, default 32, meaning the number of event lines; the only legal value is 32.
REQ-002 The block SHALL have parameter ID_W, default 5, meaning the interrupt id width.
REQ-003 The block SHALL have port clk, input, 1, the clock.
REQ-004 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-005 The block SHALL have port event_i, input, 32, synchronous event lines, rising-edge sensitive.
REQ-006 The block SHALL have port cfg_we_i, input, 1, the configuration write strobe.
REQ-007 The block SHALL have port cfg_addr_i, input, 2, the configuration register select.
REQ-008 The block SHALL have port cfg_wdata_i, input, 32, the configuration write data.
REQ-009 The block SHALL have port cfg_rdata_o, output, 32, configuration read data, combinational from cfg_addr_i.
REQ-010 The block SHALL have port irq_o, output, 1, the registered interrupt request to the core interrupt controller.
REQ-011 The block SHALL have port irq_id_o, output, 5, the id of the requested line, valid while irq_o=1.
REQ-012 The block SHALL have port irq_sec_o, output, 1, the secure attribute of the requested line, valid while irq_o=1.
REQ-013 The block SHALL have port irq_ack_i, input, 1, a one-cycle acknowledge pulse from the core.
REQ-014 The block SHALL have port irq_ack_id_i, input, 5, the id being acknowledged.
REQ-015 The block SHALL have port ack_err_o, output, 1, a one-cycle pulse on a mismatched acknowledge.

Function
REQ-016 Register map SHALL be: addr 0 MASK (read/write); addr 1 PENDING (read; write-1-to-set); addr 2 CLEAR (write-1-to-clear PENDING, reads 0); addr 3 SECURE (read/write, per-line secure attribute).
REQ-017 event_q SHALL register event_i every cycle; pending[i] SHALL be set at the edge where event_i[i]=1 and event_q[i]=0.
REQ-018 The same-cycle set sources (event edge, PENDING write) and clear sources (CLEAR write, accepted ack) on one bit SHALL resolve with set winning.
REQ-019 The candidate SHALL be the highest-index bit of pending & MASK; candidate valid SHALL be the OR-reduction of pending & MASK.
REQ-020 The FSM SHALL have states IDLE, REQ and ACKED.
REQ-021 In IDLE, the FSM SHALL go to REQ when candidate valid, latching id_q=candidate and sec_q=SECURE[candidate].
REQ-022 irq_o SHALL be 1 exactly in REQ; irq_id_o SHALL equal id_q; irq_sec_o SHALL equal sec_q and be 0 outside REQ.
REQ-023 In REQ, id_q and sec_q SHALL remain frozen even if a higher-index line becomes pending.
REQ-024 In REQ, when irq_ack_i=1 and irq_ack_id_i=id_q, the block SHALL clear pending[id_q] and go to ACKED.
REQ-025 In REQ, when irq_ack_i=1 and irq_ack_id_i!=id_q, the block SHALL pulse ack_err_o for 1 cycle, stay in REQ and leave pending unchanged.
REQ-026 In REQ with no accepted ack, if pending[id_q]=0 or MASK[id_q]=0 (software withdraw), the block SHALL return to IDLE.
REQ-027 An accepted ack SHALL take priority over a same-cycle withdraw.
REQ-028 ACKED SHALL last 1 cycle with irq_o=0, then go to IDLE; re-arbitration SHALL happen in IDLE.
REQ-029 Latency SHALL be 2 clocks: an event_i rise sampled at edge k gives pending=1 after edge k and irq_o=1 after edge k+1.
REQ-030 An irq_ack_i pulse received in IDLE or ACKED SHALL be ignored, with no ack_err_o.

Reset
REQ-031 On rst_n=0, asynchronously: MASK=0, PENDING=0, SECURE=0, event_q=0, state=IDLE, id_q=0, sec_q=0, irq_o=0, irq_sec_o=0, ack_err_o=0.
REQ-032 A reset asserted while in REQ SHALL drop irq_o immediately, and all pending events SHALL be lost.
REQ-033 An event_i line held high through reset release SHALL be detected as an edge on the first clock after release.

Structure
REQ-034 riscv_defines SHALL hold the state enum typedef and the four register address constants.
REQ-035 A sub-module riscv_irq_prio_enc (32-bit input, 5-bit index plus valid, highest index wins) SHALL be instantiated once.
REQ-036 All other logic SHALL be in the top module, with no latches.

Verification
REQ-037 Bench SHALL cover: MASK=0x80, event_i[7] rising -> irq_o=1 with irq_id_o=7 two clocks later; ack id 7 -> irq_o=0, PENDING=0.
REQ-038 Bench SHALL cover: MASK=0xFFFFFFFF, lines 3 and 20 rise together -> id 20 served first; after its ack plus ACKED, id 3 is requested.
REQ-039 Bench SHALL cover: in REQ id 5, ack with id 6 -> ack_err_o=1 for 1 cycle, irq_o stays 1, PENDING[5]=1.
REQ-040 Bench SHALL cover: in REQ id 9, CLEAR write 0x200 -> IDLE next cycle, irq_o=0, no ack needed.
REQ-041 Bench SHALL cover: line 4 rises in the same cycle its ack is accepted -> PENDING[4] stays 1 and is re-requested after ACKED.
REQ-042 Bench SHALL cover: SECURE=0x1, line 0 requested -> irq_sec_o=1; rst_n pulsed in REQ -> irq_o=0 asynchronously and all registers read 0.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared definitions for the interrupt/event unit: FSM states, register map
// addresses and small helpers.
package riscv_defines;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ACKED = 2'd2
    } irq_state_e;

    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_CLEAR   = 2'd2;
    localparam logic [1:0] ADDR_SECURE  = 2'd3;

    // One-hot vector selecting a single event line.
    function automatic logic [31:0] id_onehot(input logic [4:0] id);
        id_onehot = 32'd1 << id;
    endfunction

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// Priority encoder: reports the highest set bit of vec and whether any bit is set.
module riscv_irq_prio_enc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] idx_s;

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        idx_s = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            idx_s = vec[i] ? IDX_W'(i) : idx_s;
        end
    end

    assign idx   = idx_s;
    assign valid = |vec;

endmodule

// File: rtl/riscv_irq_event_unit.sv
// Event/interrupt unit: edge-detects event lines into a pending register and
// presents the highest masked pending line to the core, one request at a time.
module riscv_irq_event_unit
    import riscv_defines::*;
#(
    parameter int unsigned NUM_LINES = 32,
    parameter int unsigned ID_W      = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LINES-1:0] event_i,
    input  logic                 cfg_we_i,
    input  logic [1:0]           cfg_addr_i,
    input  logic [31:0]          cfg_wdata_i,
    output logic [31:0]          cfg_rdata_o,
    output logic                 irq_o,
    output logic [ID_W-1:0]      irq_id_o,
    output logic                 irq_sec_o,
    input  logic                 irq_ack_i,
    input  logic [ID_W-1:0]      irq_ack_id_i,
    output logic                 ack_err_o
);

    logic [NUM_LINES-1:0] mask_r;
    logic [NUM_LINES-1:0] pending_r;
    logic [NUM_LINES-1:0] secure_r;
    logic [NUM_LINES-1:0] event_q_r;
    irq_state_e           state_r;
    logic [ID_W-1:0]      id_r;
    logic                 sec_r;
    logic                 irq_r;
    logic                 irq_sec_r;
    logic                 ack_err_r;

    irq_state_e           state_s;
    logic [ID_W-1:0]      id_s;
    logic                 sec_s;
    logic [NUM_LINES-1:0] active_s;
    logic [NUM_LINES-1:0] set_s;
    logic [NUM_LINES-1:0] clr_s;
    logic [NUM_LINES-1:0] pending_s;
    logic [ID_W-1:0]      cand_id_s;
    logic                 cand_valid_s;
    logic                 wr_mask_s;
    logic                 wr_pending_s;
    logic                 wr_clear_s;
    logic                 wr_secure_s;
    logic                 ack_hit_s;
    logic                 ack_miss_s;

    assign active_s = pending_r & mask_r;

    riscv_irq_prio_enc #(
        .WIDTH (NUM_LINES),
        .IDX_W (ID_W)
    ) u_prio_enc (
        .vec   (active_s),
        .idx   (cand_id_s),
        .valid (cand_valid_s)
    );

    // Configuration write decode.
    always_comb begin
        wr_mask_s    = 1'b0;
        wr_pending_s = 1'b0;
        wr_clear_s   = 1'b0;
        wr_secure_s  = 1'b0;
        if (cfg_we_i) begin
            case (cfg_addr_i)
                ADDR_MASK:    wr_mask_s    = 1'b1;
                ADDR_PENDING: wr_pending_s = 1'b1;
                ADDR_CLEAR:   wr_clear_s   = 1'b1;
                ADDR_SECURE:  wr_secure_s  = 1'b1;
                default:      wr_mask_s    = 1'b0;
            endcase
        end else begin
            wr_mask_s = 1'b0;
        end
    end

    assign ack_hit_s  = (state_r == ST_REQ) && irq_ack_i && (irq_ack_id_i == id_r);
    assign ack_miss_s = (state_r == ST_REQ) && irq_ack_i && (irq_ack_id_i != id_r);

    // Pending next value: clear sources first, set sources OR-ed last so set wins.
    always_comb begin
        set_s     = (event_i & ~event_q_r)
                  | (wr_pending_s ? cfg_wdata_i : {NUM_LINES{1'b0}});
        clr_s     = (wr_clear_s ? cfg_wdata_i : {NUM_LINES{1'b0}})
                  | (ack_hit_s ? id_onehot(id_r) : {NUM_LINES{1'b0}});
        pending_s = (pending_r & ~clr_s) | set_s;
    end

    // Request FSM next state; id/secure attribute are latched only on leaving IDLE.
    always_comb begin
        state_s = state_r;
        id_s    = id_r;
        sec_s   = sec_r;
        case (state_r)
            ST_IDLE: begin
                if (cand_valid_s) begin
                    state_s = ST_REQ;
                    id_s    = cand_id_s;
                    sec_s   = secure_r[cand_id_s];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_hit_s) begin
                    state_s = ST_ACKED;
                end else if (ack_miss_s) begin
                    state_s = ST_REQ;
                end else if (!pending_r[id_r] || !mask_r[id_r]) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_ACKED: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State, configuration and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r    <= {NUM_LINES{1'b0}};
            pending_r <= {NUM_LINES{1'b0}};
            secure_r  <= {NUM_LINES{1'b0}};
            event_q_r <= {NUM_LINES{1'b0}};
            state_r   <= ST_IDLE;
            id_r      <= {ID_W{1'b0}};
            sec_r     <= 1'b0;
            irq_r     <= 1'b0;
            irq_sec_r <= 1'b0;
            ack_err_r <= 1'b0;
        end else begin
            mask_r    <= wr_mask_s ? cfg_wdata_i : mask_r;
            secure_r  <= wr_secure_s ? cfg_wdata_i : secure_r;
            pending_r <= pending_s;
            event_q_r <= event_i;
            state_r   <= state_s;
            id_r      <= id_s;
            sec_r     <= sec_s;
            irq_r     <= (state_s == ST_REQ);
            irq_sec_r <= (state_s == ST_REQ) && sec_s;
            ack_err_r <= ack_miss_s;
        end
    end

    // Register readback; CLEAR is write-only and reads as zero.
    always_comb begin
        cfg_rdata_o = 32'd0;
        case (cfg_addr_i)
            ADDR_MASK:    cfg_rdata_o = mask_r;
            ADDR_PENDING: cfg_rdata_o = pending_r;
            ADDR_CLEAR:   cfg_rdata_o = 32'd0;
            ADDR_SECURE:  cfg_rdata_o = secure_r;
            default:      cfg_rdata_o = 32'd0;
        endcase
    end

    assign irq_o     = irq_r;
    assign irq_id_o  = id_r;
    assign irq_sec_o = irq_sec_r;
    assign ack_err_o = ack_err_r;

endmodule

// File: tb/tb_riscv_irq_event_unit.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model of the event unit.
module tb_riscv_irq_event_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] event_i;
    logic        cfg_we_i;
    logic [1:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic [31:0] cfg_rdata_o;
    logic        irq_o;
    logic [4:0]  irq_id_o;
    logic        irq_sec_o;
    logic        irq_ack_i;
    logic [4:0]  irq_ack_id_i;
    logic        ack_err_o;

    riscv_irq_event_unit #(.NUM_LINES(32), .ID_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .event_i      (event_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .cfg_rdata_o  (cfg_rdata_o),
        .irq_o        (irq_o),
        .irq_id_o     (irq_id_o),
        .irq_sec_o    (irq_sec_o),
        .irq_ack_i    (irq_ack_i),
        .irq_ack_id_i (irq_ack_id_i),
        .ack_err_o    (ack_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model
    localparam int P_IDLE  = 0;
    localparam int P_REQ   = 1;
    localparam int P_ACKED = 2;
    int          m_phase;
    logic [31:0] m_mask, m_pend, m_sec, m_evq;
    logic [4:0]  m_id;
    logic        m_secq, m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_mask = 32'd0; m_pend = 32'd0; m_sec = 32'd0; m_evq = 32'd0;
        m_id = 5'd0; m_secq = 1'b0; m_err = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_mask;
            2'd1:    return m_pend;
            2'd3:    return m_sec;
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge of the model, from the inputs held across that edge.
    task automatic model_clock();
        logic [31:0] setm, clrm, act;
        bit acc, mis;
        setm = (event_i & ~m_evq) | ((cfg_we_i && cfg_addr_i == 2'd1) ? cfg_wdata_i : 32'd0);
        clrm = (cfg_we_i && cfg_addr_i == 2'd2) ? cfg_wdata_i : 32'd0;
        acc  = (m_phase == P_REQ) && irq_ack_i && (irq_ack_id_i == m_id);
        mis  = (m_phase == P_REQ) && irq_ack_i && (irq_ack_id_i != m_id);
        if (acc) clrm[m_id] = 1'b1;
        act = m_pend & m_mask;
        if (m_phase == P_IDLE) begin
            if (act != 32'd0) begin
                for (int i = 31; i >= 0; i--) begin
                    if (act[i]) begin
                        m_id = 5'(i);
                        break;
                    end
                end
                m_secq  = m_sec[m_id];
                m_phase = P_REQ;
            end
        end else if (m_phase == P_REQ) begin
            if (acc) m_phase = P_ACKED;
            else if (!mis && (!m_pend[m_id] || !m_mask[m_id])) m_phase = P_IDLE;
        end else begin
            m_phase = P_IDLE;
        end
        m_pend = (m_pend & ~clrm) | setm;
        if (cfg_we_i && cfg_addr_i == 2'd0) m_mask = cfg_wdata_i;
        if (cfg_we_i && cfg_addr_i == 2'd3) m_sec = cfg_wdata_i;
        m_evq = event_i;
        m_err = mis;
    endtask

    task automatic compare_all();
        logic exp_irq;
        exp_irq = (m_phase == P_REQ);
        check("irq_o", {31'd0, irq_o}, {31'd0, exp_irq});
        if (exp_irq) check("irq_id_o", {27'd0, irq_id_o}, {27'd0, m_id});
        check("irq_sec_o", {31'd0, irq_sec_o}, {31'd0, exp_irq & m_secq});
        check("ack_err_o", {31'd0, ack_err_o}, {31'd0, m_err});
        check("cfg_rdata_o", cfg_rdata_o, model_read(cfg_addr_i));
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d;
        step();
        cfg_we_i = 1'b0;
    endtask

    task automatic ack(input logic [4:0] id);
        irq_ack_i = 1'b1; irq_ack_id_i = id;
        step();
        irq_ack_i = 1'b0;
    endtask

    task automatic read_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
        cfg_addr_i = a;
        #1;
        check(name, cfg_rdata_o, exp);
    endtask

    initial begin
        rst_n = 1'b0; event_i = 32'd0; cfg_we_i = 1'b0; cfg_addr_i = 2'd0;
        cfg_wdata_i = 32'd0; irq_ack_i = 1'b0; irq_ack_id_i = 5'd0;
        model_reset();
        @(negedge clk);
        compare_all();
        read_reg("rst_pending", 2'd1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single line, two-clock latency, ack clears pending
        wr(2'd0, 32'h0000_0080);
        event_i[7] = 1'b1;
        step();
        read_reg("s1_pend_set", 2'd1, 32'h0000_0080);
        check("s1_irq_not_yet", {31'd0, irq_o}, 32'd0);
        step();
        check("s1_irq", {31'd0, irq_o}, 32'd1);
        check("s1_id", {27'd0, irq_id_o}, 32'd7);
        ack(5'd7);
        check("s1_irq_drop", {31'd0, irq_o}, 32'd0);
        read_reg("s1_pend_clr", 2'd1, 32'd0);
        event_i = 32'd0;
        step();

        // Highest index first, then the lower line after ACKED
        wr(2'd0, 32'hFFFF_FFFF);
        event_i = 32'h0010_0008;
        step();
        step();
        check("s2_id_first", {27'd0, irq_id_o}, 32'd20);
        event_i = 32'd0;
        ack(5'd20);
        check("s2_acked_low", {31'd0, irq_o}, 32'd0);
        step();
        step();
        check("s2_irq_second", {31'd0, irq_o}, 32'd1);
        check("s2_id_second", {27'd0, irq_id_o}, 32'd3);
        ack(5'd3);
        step();

        // Mismatched ack
        event_i[5] = 1'b1;
        step();
        step();
        check("s3_id", {27'd0, irq_id_o}, 32'd5);
        event_i = 32'd0;
        ack(5'd6);
        check("s3_ack_err", {31'd0, ack_err_o}, 32'd1);
        check("s3_irq_held", {31'd0, irq_o}, 32'd1);
        read_reg("s3_pend", 2'd1, 32'h0000_0020);
        step();
        check("s3_ack_err_pulse", {31'd0, ack_err_o}, 32'd0);
        ack(5'd5);
        step();

        // Software withdraw through CLEAR
        event_i[9] = 1'b1;
        step();
        step();
        check("s4_id", {27'd0, irq_id_o}, 32'd9);
        event_i = 32'd0;
        wr(2'd2, 32'h0000_0200);
        step();
        check("s4_withdrawn", {31'd0, irq_o}, 32'd0);
        step();

        // Event edge coinciding with its own accepted ack
        event_i[4] = 1'b1;
        step();
        step();
        check("s5_id", {27'd0, irq_id_o}, 32'd4);
        event_i = 32'd0;
        step();
        event_i[4] = 1'b1;
        ack(5'd4);
        read_reg("s5_pend_kept", 2'd1, 32'h0000_0010);
        event_i = 32'd0;
        step();
        step();
        check("s5_rereq", {31'd0, irq_o}, 32'd1);
        check("s5_rereq_id", {27'd0, irq_id_o}, 32'd4);
        ack(5'd4);
        step();

        // Secure attribute, then asynchronous reset while requesting
        wr(2'd3, 32'h0000_0001);
        event_i[0] = 1'b1;
        step();
        step();
        check("s6_sec", {31'd0, irq_sec_o}, 32'd1);
        check("s6_id", {27'd0, irq_id_o}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_async_irq", {31'd0, irq_o}, 32'd0);
        check("s6_async_sec", {31'd0, irq_sec_o}, 32'd0);
        read_reg("s6_mask0", 2'd0, 32'd0);
        read_reg("s6_pend0", 2'd1, 32'd0);
        read_reg("s6_clr0", 2'd2, 32'd0);
        read_reg("s6_sec0", 2'd3, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        read_reg("s6_held_edge", 2'd1, 32'h0000_0001);
        event_i = 32'd0;
        step();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            event_i     = event_i ^ ($urandom & $urandom & $urandom);
            cfg_we_i    = ($urandom_range(0, 7) == 0);
            cfg_addr_i  = 2'($urandom_range(0, 3));
            cfg_wdata_i = $urandom;
            irq_ack_i   = ($urandom_range(0, 3) == 0);
            irq_ack_id_i = ($urandom_range(0, 1) == 1) ? m_id : 5'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
